// File: rtl/dmem_wait_bridge_pkg.sv
// Shared types and constants for the processor-to-dmem wait-state bridge.
package dmem_bridge_pkg;

    // State encodings
    localparam logic [1:0] IDLE_ENC   = 2'd0;
    localparam logic [1:0] WAIT_ENC   = 2'd1;
    localparam logic [1:0] ACCESS_ENC = 2'd2;
    localparam logic [1:0] RESP_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE_ENC,
        ST_WAIT   = WAIT_ENC,
        ST_ACCESS = ACCESS_ENC,
        ST_RESP   = RESP_ENC
    } state_e;

    // Captured request type
    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_type_e;

    // Width of a counter that must hold max(a, b); never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dmem_wait_bridge_if.sv
// Bus bundle between processor data port, bridge and dmem.
// slave = bridge view, master = environment (processor + dmem) view.
interface dmem_wait_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    // Processor side
    logic [ADDR_WIDTH-1:0]   ip_data_addr;
    logic                    ip_data_wr;
    logic [DATA_WIDTH/8-1:0] ip_data_mask;
    logic [DATA_WIDTH-1:0]   ip_data_from_proc;
    logic                    ip_data_rd;
    logic                    op_data_valid;
    logic [DATA_WIDTH-1:0]   op_data_from_dmem;
    logic                    op_data_err;
    logic                    op_busy;
    // Memory side
    logic [ADDR_WIDTH-1:0]   op_mem_addr;
    logic                    op_mem_wr;
    logic [DATA_WIDTH/8-1:0] op_mem_mask;
    logic [DATA_WIDTH-1:0]   op_mem_wdata;
    logic                    op_mem_rd;
    logic                    ip_mem_valid;
    logic [DATA_WIDTH-1:0]   ip_mem_rdata;

    modport slave (
        input  ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
        output op_data_valid, op_data_from_dmem, op_data_err, op_busy,
        output op_mem_addr, op_mem_wr, op_mem_mask, op_mem_wdata, op_mem_rd,
        input  ip_mem_valid, ip_mem_rdata
    );

    modport master (
        output ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
        input  op_data_valid, op_data_from_dmem, op_data_err, op_busy,
        input  op_mem_addr, op_mem_wr, op_mem_mask, op_mem_wdata, op_mem_rd,
        output ip_mem_valid, ip_mem_rdata
    );
endinterface

// File: rtl/dmem_wait_bridge_down_counter.sv
// Loadable down-counter with zero/one flags; used for wait states and timeout.
module dmem_bridge_down_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             one_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority; decrement stops at zero so the count never wraps.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
    assign one_o  = (count_q == WIDTH'(1));

endmodule

// File: rtl/dmem_wait_bridge.sv
// Registered processor/dmem bridge: one request at a time, WAIT_CYCLES wait
// states before the single dmem access, one-cycle completion pulse, and a
// timeout error if dmem never returns read data.
module dmem_wait_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 15
) (
    input logic               clk,
    input logic               reset,
    dmem_wait_bridge_if.slave bus
);
    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int CNT_W  = cnt_width(WAIT_CYCLES, TIMEOUT);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT);

    state_e                  state_q, state_d;
    req_type_e               type_q, type_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [MASK_W-1:0]       mask_q, mask_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic accept;
    logic wait_dec, wait_zero, wait_one;
    logic to_dec, to_zero, to_one;

    // Wait-state counter: loaded when a request is accepted, counts down in WAIT.
    dmem_bridge_down_counter #(.WIDTH(CNT_W)) u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .load_val_i (WAIT_LOAD),
        .dec_i      (wait_dec),
        .zero_o     (wait_zero),
        .one_o      (wait_one)
    );

    // Timeout counter: loaded on accept, counts read ACCESS cycles without valid.
    dmem_bridge_down_counter #(.WIDTH(CNT_W)) u_to_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .load_val_i (TO_LOAD),
        .dec_i      (to_dec),
        .zero_o     (to_zero),
        .one_o      (to_one)
    );

    // Next-state and datapath capture logic.
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        accept   = 1'b0;
        wait_dec = 1'b0;
        to_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (bus.ip_data_wr || bus.ip_data_rd) begin
                    accept  = 1'b1;
                    addr_d  = bus.ip_data_addr;
                    mask_d  = bus.ip_data_mask;
                    wdata_d = bus.ip_data_from_proc;
                    // Write wins when both strobes are high.
                    type_d  = bus.ip_data_wr ? REQ_WR : REQ_RD;
                    state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_dec = 1'b1;
                // Zero check only guards against an unexpected empty count.
                if (wait_one || wait_zero) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (type_q == REQ_WR) begin
                    state_d = ST_RESP;
                end else if (bus.ip_mem_valid) begin
                    rdata_d = bus.ip_mem_rdata;
                    state_d = ST_RESP;
                end else if (to_one || to_zero) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    to_dec = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            type_q  <= REQ_RD;
            addr_q  <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from registers only; address/mask/data stay stable for dmem.
    assign bus.op_busy           = (state_q != ST_IDLE);
    assign bus.op_data_valid     = (state_q == ST_RESP);
    assign bus.op_data_err       = (state_q == ST_RESP) && err_q;
    assign bus.op_data_from_dmem = rdata_q;
    assign bus.op_mem_wr         = (state_q == ST_ACCESS) && (type_q == REQ_WR);
    assign bus.op_mem_rd         = (state_q == ST_ACCESS) && (type_q == REQ_RD);
    assign bus.op_mem_addr       = addr_q;
    assign bus.op_mem_mask       = mask_q;
    assign bus.op_mem_wdata      = wdata_q;

endmodule
